// File: rtl/seg_scan_ctrl.sv
// Multiplexed seven-segment scan controller: blank guard then dwell per digit,
// with a shadow frame that is swapped into the active frame only at scan wrap.
module seg_scan_ctrl #(
  parameter int N_DIGITS     = 8,
  parameter int DWELL_CYCLES = 100000,
  parameter int BLANK_CYCLES = 1000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic [4*N_DIGITS-1:0] data_in,
  input  logic [N_DIGITS-1:0]   en_in,
  input  logic [N_DIGITS-1:0]   dp_in,
  output logic                  ready,
  output logic [3:0]            digit,
  output logic [N_DIGITS-1:0]   an,
  output logic                  dp_n,
  output logic                  frame_done
);

  localparam int CMAX = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
  localparam int CW   = (CMAX > 1) ? $clog2(CMAX) : 1;
  localparam int IW   = $clog2(N_DIGITS);

  localparam logic [CW-1:0] DWELL_LAST = CW'(DWELL_CYCLES - 1);
  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);
  localparam logic [IW-1:0] IDX_LAST   = IW'(N_DIGITS - 1);

  typedef enum logic {BLANK, SHOW} state_t;

  state_t                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [4*N_DIGITS-1:0] act_data_q, act_data_d, sh_data_q;
  logic [N_DIGITS-1:0]   act_en_q, act_en_d, sh_en_q;
  logic [N_DIGITS-1:0]   act_dp_q, act_dp_d, sh_dp_q;
  logic                  pend_q, pend_d;
  logic                  wrap, apply, accept;
  logic [N_DIGITS-1:0]   onehot;
  logic [3:0]            digit_d;
  logic [N_DIGITS-1:0]   an_d;
  logic                  dp_n_d, frame_done_d;

  // Outputs are registered from next-cycle values so they line up with state/idx.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CW'(1);
    idx_d   = idx_q;
    case (state_q)
      BLANK: begin
        if (cnt_q == BLANK_LAST) begin
          state_d = SHOW;
          cnt_d   = '0;
        end
      end
      SHOW: begin
        if (cnt_q == DWELL_LAST) begin
          state_d = BLANK;
          cnt_d   = '0;
          idx_d   = (idx_q == IDX_LAST) ? '0 : idx_q + IW'(1);
        end
      end
      default: begin
        state_d = BLANK;
        cnt_d   = '0;
      end
    endcase

    wrap   = (state_q == SHOW) && (cnt_q == DWELL_LAST) && (idx_q == IDX_LAST);
    apply  = wrap && pend_q;
    accept = load && !pend_q;

    act_data_d = apply ? sh_data_q : act_data_q;
    act_en_d   = apply ? sh_en_q   : act_en_q;
    act_dp_d   = apply ? sh_dp_q   : act_dp_q;

    pend_d = pend_q;
    if (apply)  pend_d = 1'b0;
    if (accept) pend_d = 1'b1;

    onehot       = N_DIGITS'(1) << idx_d;
    digit_d      = act_data_d[{idx_d, 2'b00} +: 4];
    an_d         = (state_d == SHOW) ? ~(onehot & act_en_d) : '1;
    dp_n_d       = (state_d == SHOW) ? ~(act_dp_d[idx_d] & act_en_d[idx_d]) : 1'b1;
    frame_done_d = (state_d == SHOW) && (cnt_d == DWELL_LAST) && (idx_d == IDX_LAST);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= BLANK;
      cnt_q      <= '0;
      idx_q      <= '0;
      act_data_q <= '0;
      act_en_q   <= '0;
      act_dp_q   <= '0;
      sh_data_q  <= '0;
      sh_en_q    <= '0;
      sh_dp_q    <= '0;
      pend_q     <= 1'b0;
      digit      <= '0;
      an         <= '1;
      dp_n       <= 1'b1;
      frame_done <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      act_data_q <= act_data_d;
      act_en_q   <= act_en_d;
      act_dp_q   <= act_dp_d;
      pend_q     <= pend_d;
      if (accept) begin
        sh_data_q <= data_in;
        sh_en_q   <= en_in;
        sh_dp_q   <= dp_in;
      end
      digit      <= digit_d;
      an         <= an_d;
      dp_n       <= dp_n_d;
      frame_done <= frame_done_d;
    end
  end

  assign ready = ~pend_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Scoreboard bench for seg_scan_ctrl with a small frame-position model of the
// scan and the shadow/active frame handoff.
module tb_seg_scan_ctrl;

  localparam int ND = 4;
  localparam int DW = 4;
  localparam int BL = 1;
  localparam int SLOT = DW + BL;
  localparam int FL = ND * SLOT;

  logic        clk = 1'b0;
  logic        rst;
  logic        load;
  logic [15:0] data_in;
  logic [3:0]  en_in;
  logic [3:0]  dp_in;
  logic        ready;
  logic [3:0]  digit;
  logic [3:0]  an;
  logic        dp_n;
  logic        frame_done;

  always #5 clk = ~clk;

  seg_scan_ctrl #(
    .N_DIGITS    (ND),
    .DWELL_CYCLES(DW),
    .BLANK_CYCLES(BL)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .load      (load),
    .data_in   (data_in),
    .en_in     (en_in),
    .dp_in     (dp_in),
    .ready     (ready),
    .digit     (digit),
    .an        (an),
    .dp_n      (dp_n),
    .frame_done(frame_done)
  );

  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  logic [10:0] sb_q[$];

  int          m_t;
  logic [15:0] m_act_data, m_sh_data;
  logic [3:0]  m_act_en, m_sh_en, m_act_dp, m_sh_dp;
  logic        m_pend;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Expected {ready, frame_done, dp_n, an, digit} for the model's current position.
  function automatic logic [10:0] expectedOut();
    int         slot;
    logic       show;
    logic [3:0] lit;
    logic [3:0] e_an;
    logic       e_dp;
    slot = m_t / SLOT;
    show = (m_t % SLOT) >= BL;
    lit  = 4'b0001;
    lit  = lit << slot;
    e_an = show ? ~(lit & m_act_en) : 4'hF;
    e_dp = show ? ~(m_act_dp[slot] & m_act_en[slot]) : 1'b1;
    return {~m_pend, (m_t == FL - 1), e_dp, e_an, m_act_data[slot*4 +: 4]};
  endfunction

  task automatic applyStimulus(input logic r, input logic l, input logic [15:0] d,
                               input logic [3:0] e, input logic [3:0] p);
    logic        wrap;
    logic        old_pend;
    logic [10:0] exp_v;
    rst = r; load = l; data_in = d; en_in = e; dp_in = p;
    if (r) begin
      m_t = 0; m_pend = 1'b0;
      m_act_data = '0; m_act_en = '0; m_act_dp = '0;
      m_sh_data  = '0; m_sh_en  = '0; m_sh_dp  = '0;
    end else begin
      wrap = (m_t == FL - 1);
      old_pend = m_pend;
      if (wrap && m_pend) begin
        m_act_data = m_sh_data; m_act_en = m_sh_en; m_act_dp = m_sh_dp;
        m_pend = 1'b0;
      end
      if (l && !old_pend) begin
        m_sh_data = d; m_sh_en = e; m_sh_dp = p;
        m_pend = 1'b1;
      end
      m_t = wrap ? 0 : m_t + 1;
    end
    sb_q.push_back(expectedOut());
    @(posedge clk);
    #1;
    if (r) cyc = 1; else cyc++;
    exp_v = sb_q.pop_front();
    checkOutput($sformatf("cyc%0d", cyc), {21'b0, ready, frame_done, dp_n, an, digit}, {21'b0, exp_v});
  endtask

  task automatic idleUntil(input int target);
    int guard;
    guard = 0;
    while (cyc < target && guard < 1000) begin
      applyStimulus(1'b0, 1'b0, 16'h0, 4'h0, 4'h0);
      guard++;
    end
  endtask

  initial begin
    logic [31:0] rnd;
    rst = 1'b1; load = 1'b0; data_in = '0; en_in = '0; dp_in = '0;
    #2;
    applyStimulus(1'b1, 1'b1, 16'hDEAD, 4'hF, 4'hF);
    applyStimulus(1'b1, 1'b0, 16'h0, 4'h0, 4'h0);
    checkOutput("rst_an", {28'b0, an}, 32'hF);
    checkOutput("rst_ready", {31'b0, ready}, 32'h1);

    applyStimulus(1'b0, 1'b0, 16'h0, 4'h0, 4'h0);
    applyStimulus(1'b0, 1'b1, 16'h1234, 4'b1111, 4'b0010);
    checkOutput("load_ready0", {31'b0, ready}, 32'h0);
    idleUntil(5);
    applyStimulus(1'b0, 1'b1, 16'hFFFF, 4'hF, 4'hF);
    idleUntil(20);
    checkOutput("fd_c20", {31'b0, frame_done}, 32'h1);
    idleUntil(21);
    checkOutput("c21_ready", {31'b0, ready}, 32'h1);
    checkOutput("c21_an_digit", {24'b0, an, digit}, 32'hF4);
    idleUntil(22);
    checkOutput("c22_an_digit_dp", {23'b0, dp_n, an, digit}, 32'h1E4);
    idleUntil(27);
    checkOutput("c27_an_digit_dp", {23'b0, dp_n, an, digit}, 32'h0D3);

    idleUntil(40);
    applyStimulus(1'b0, 1'b1, 16'h8888, 4'b0101, 4'b1111);
    checkOutput("wrapload_digit_old", {28'b0, digit}, 32'h4);
    idleUntil(61);
    checkOutput("wrapload_digit_new", {28'b0, digit}, 32'h8);
    idleUntil(62);
    checkOutput("en0101_idx0_an", {28'b0, an}, 32'hE);
    idleUntil(67);
    checkOutput("en0101_idx1_an_dp", {27'b0, dp_n, an}, 32'h1F);
    idleUntil(100);

    applyStimulus(1'b0, 1'b1, 16'hABCD, 4'hF, 4'hF);
    idleUntil(113);
    applyStimulus(1'b1, 1'b0, 16'h0, 4'h0, 4'h0);
    checkOutput("midrst_an_ready", {27'b0, ready, an}, 32'h1F);
    idleUntil(26);

    for (int i = 0; i < 120; i++) begin
      rnd = $urandom;
      applyStimulus(1'b0, rnd[1:0] == 2'b00, rnd[31:16], rnd[7:4], rnd[11:8]);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/seg_scan_ctrl.md
SEG_SCAN_CTRL -- requirements
Module: seg_scan_ctrl

Interface
REQ-001 Parameter N_DIGITS, default 8: number of multiplexed digits, range 2..8.
REQ-002 Parameter DWELL_CYCLES, default 100000: clocks each digit is lit per scan slot, at least 1.
REQ-003 Parameter BLANK_CYCLES, default 1000: all-off clocks before each digit slot (ghosting guard), at least 1.
REQ-004 Port clk  input  1: the single clock; all state changes on its rising edge.
REQ-005 Port rst  input  1: reset, synchronous and active-high.
REQ-006 Port load  input  1: request to accept a new frame; accepted only in a cycle where ready=1.
REQ-007 Port data_in  input  4*N_DIGITS: hex nibble per digit, digit i at bits [4i+3:4i].
REQ-008 Port en_in  input  N_DIGITS: per-digit enable; 0 keeps that digit dark.
REQ-009 Port dp_in  input  N_DIGITS: per-digit decimal point, 1 = lit.
REQ-010 Port ready  output  1: 1 when no accepted frame is pending.
REQ-011 Port digit  output  4: nibble of the current digit, fed to the hex-to-segment decoder.
REQ-012 Port an  output  N_DIGITS: anode selects, active-low.
REQ-013 Port dp_n  output  1: decimal point, active-low.
REQ-014 Port frame_done  output  1: one-cycle pulse on the last SHOW cycle of digit N_DIGITS-1.

Function
REQ-015 Two states: BLANK and SHOW. A cycle counter counts 0..BLANK_CYCLES-1 in BLANK and 0..DWELL_CYCLES-1 in SHOW. A digit index idx runs 0..N_DIGITS-1.
REQ-016 BLANK to SHOW when the counter reaches BLANK_CYCLES-1; the counter clears and idx is held.
REQ-017 SHOW to BLANK when the counter reaches DWELL_CYCLES-1; the counter clears and idx increments. Index N_DIGITS-1 wraps to 0; this last SHOW cycle is the wrap cycle.
REQ-018 A full frame lasts N_DIGITS*(BLANK_CYCLES+DWELL_CYCLES) cycles.
REQ-019 Active register set: act_data, act_en, act_dp. Shadow register set: sh_data, sh_en, sh_dp. Pending flag: pend.
REQ-020 ready is exactly ~pend, a registered flag with no combinational path from load.
REQ-021 With load=1 and ready=1 at a clock edge: data_in, en_in and dp_in are captured into the shadow set and pend is set. With load=1 and ready=0: the request is ignored and the shadow set is unchanged.
REQ-022 At the wrap-cycle edge with pend=1: the shadow set is copied to the active set and pend clears. Frames therefore change only between scans, never mid-frame.
REQ-023 A load accepted in the wrap cycle itself sets pend. It is applied at the following wrap, not the current one.
REQ-024 digit is act_data nibble [idx] in both BLANK and SHOW, so the decoder settles during BLANK.
REQ-025 In SHOW, an has bit idx = ~act_en[idx] and all other bits 1. In BLANK, an is all ones.
REQ-026 In SHOW, dp_n = ~(act_dp[idx] & act_en[idx]). In BLANK, dp_n = 1.
REQ-027 an, dp_n and digit are registered outputs. They reflect the state and idx of the same cycle, with no glitch across a state change.
REQ-028 frame_done is 1 only in the wrap cycle, whatever the value of pend.

Reset
REQ-029 While rst=1 at a clock edge, the following reset values apply:
- state = BLANK, counter = 0, idx = 0
- act_* and sh_* = 0, pend = 0
- outputs: an = all ones, dp_n = 1, digit = 0, ready = 1, frame_done = 0
REQ-030 Reset mid-frame or with a frame pending discards the pending frame and the active frame; the display stays dark until a new load is applied at a wrap.
REQ-031 When rst=1 and load=1 occur together, reset wins and the load is not captured.

Verification (N_DIGITS=4, DWELL_CYCLES=4, BLANK_CYCLES=1)
REQ-032 Reset release, no load -> an=1111 and dp_n=1 for 40 cycles; frame_done pulses every 20 cycles, first at cycle 20 (cycle 1 = first cycle after release, counter=0).
REQ-033 load at cycle 2 with data_in=0x1234, en_in=1111, dp_in=0010 -> ready=0 from cycle 3; apply at cycle-20 wrap, ready=1 from cycle 21; then:
- cycle 21: an=1111, digit=4
- cycles 22-25: an=1110, digit=4, dp_n=1
- cycles 27-30: an=1101, digit=3, dp_n=0
REQ-034 Second load while ready=0 with data_in=0xFFFF -> ignored; the displayed frame remains 0x1234.
REQ-035 load asserted exactly on a wrap cycle with pend=0 -> captured; the current frame is unchanged and the new data appears only after the next wrap, 20 cycles later.
REQ-036 en_in=0101, data_in=0x8888 applied -> in each frame, only idx 0 and 2 ever drive an low; during the idx 1 and 3 slots, an stays 1111 and dp_n=1.
REQ-037 rst pulsed for one cycle during idx=2 SHOW with pend=1 -> the next cycle shows BLANK, idx=0, an=1111, ready=1; the display stays dark through the next frame.
